// File: rtl/snn_pkg.sv
// Shared SNN constants and the Wishbone loader state encoding.
package snn_pkg;

    localparam int NUM_PIXELS   = 196;
    localparam int OUTPUTS      = 10;
    localparam int HALF_WEIGHTS = NUM_PIXELS * OUTPUTS / 2;

    localparam logic [31:0] WEIGHTS_BASE = 32'h3000_0000;

    localparam int LDR_MAX_BYTES = 2 * HALF_WEIGHTS;
    localparam int LDR_SRAM_AW   = 10;
    localparam int LDR_TIMEOUT   = 255;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_REQ    = 3'd1,
        LDR_UNPACK = 3'd2,
        LDR_DONE   = 3'd3,
        LDR_ERR    = 3'd4
    } ldr_state_t;

    function automatic logic [11:0] clamp_count(input logic [11:0] req, input logic [11:0] limit);
        return (req > limit) ? limit : req;
    endfunction

endpackage

// File: rtl/snn_wb_loader_if.sv
// Read-only Wishbone classic bus between the loader (master) and system memory.
interface snn_wb_loader_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic        err;

    modport master (output cyc, stb, we, sel, adr, input dat, ack, err);
    modport slave  (input cyc, stb, we, sel, adr, output dat, ack, err);
endinterface

// File: rtl/snn_byte_unpacker.sv
// Holds one fetched word and walks its bytes, tracking the global byte index
// and mapping it onto the two SRAM banks.
module snn_byte_unpacker
    import snn_pkg::*;
#(
    parameter int SPLIT   = HALF_WEIGHTS,
    parameter int SRAM_AW = LDR_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic               step,
    input  logic [31:0]        word_in,
    output logic [1:0]         lane,
    output logic [11:0]        byte_idx,
    output logic               bank,
    output logic [SRAM_AW-1:0] addr,
    output logic [7:0]         data
);

    logic [31:0] word;

    always_ff @(posedge clk) begin
        if (rst) begin
            word     <= 32'h0;
            lane     <= 2'd0;
            byte_idx <= 12'd0;
        end else if (clear) begin
            lane     <= 2'd0;
            byte_idx <= 12'd0;
        end else if (load) begin
            word <= word_in;
            lane <= 2'd0;
        end else if (step) begin
            lane     <= lane + 2'd1;
            byte_idx <= byte_idx + 12'd1;
        end
    end

    always_comb begin
        bank = (byte_idx >= 12'(SPLIT));
        addr = bank ? SRAM_AW'(byte_idx - 12'(SPLIT)) : SRAM_AW'(byte_idx);
        data = word[{lane, 3'b000} +: 8];
    end

endmodule

// File: rtl/snn_wb_loader.sv
// Wishbone initiator that streams words from system memory into the SNN
// weight/image SRAMs, one little-endian byte per cycle.
//
// state  | meaning
// IDLE   | waiting for start
// REQ    | cyc/stb held until ack, err or timeout
// UNPACK | one SRAM byte write per cycle from the captured word
// DONE   | one-cycle done pulse
// ERR    | bus error or timeout; error flag set, back to IDLE
module snn_wb_loader
    import snn_pkg::*;
#(
    parameter int SPLIT     = HALF_WEIGHTS,
    parameter int MAX_BYTES = LDR_MAX_BYTES,
    parameter int SRAM_AW   = LDR_SRAM_AW,
    parameter int TIMEOUT   = LDR_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        src_addr,
    input  logic [11:0]        byte_count,
    snn_wb_loader_if.master    wb,
    output logic               sram_bank,
    output logic               sram_we,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [7:0]         sram_data,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    ldr_state_t         state, state_next;
    logic               accept;
    logic               load_word;
    logic               last_byte;
    logic [31:0]        adr;
    logic [11:0]        count;
    logic [11:0]        count_req;
    logic [TW-1:0]      tmr;
    logic [1:0]         u_lane;
    logic [11:0]        u_idx;
    logic               u_bank;
    logic [SRAM_AW-1:0] u_addr;
    logic [7:0]         u_data;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^src_addr[1:0];
    assign count_req        = clamp_count(byte_count, 12'(MAX_BYTES));
    assign last_byte        = (u_idx == count - 12'd1);
    assign load_word        = (state == LDR_REQ) && wb.ack && !wb.err;

    always_ff @(posedge clk) begin
        if (rst) state <= LDR_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            LDR_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (count_req == 12'd0) ? LDR_DONE : LDR_REQ;
                end
            end
            LDR_REQ: begin
                // err outranks a simultaneous ack
                if (wb.err)              state_next = LDR_ERR;
                else if (wb.ack)         state_next = LDR_UNPACK;
                else if (tmr == TW'(1))  state_next = LDR_ERR;
            end
            LDR_UNPACK: begin
                if (last_byte)           state_next = LDR_DONE;
                else if (u_lane == 2'd3) state_next = LDR_REQ;
            end
            LDR_DONE: state_next = LDR_IDLE;
            LDR_ERR:  state_next = LDR_IDLE;
            default:  state_next = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr   <= 32'h0;
            count <= 12'd0;
            tmr   <= '0;
            error <= 1'b0;
        end else begin
            if (accept) begin
                adr   <= {src_addr[31:2], 2'b00};
                count <= count_req;
                error <= 1'b0;
            end else if (state == LDR_UNPACK && state_next == LDR_REQ) begin
                adr <= adr + 32'd4;
            end

            if (state_next == LDR_ERR) error <= 1'b1;

            // Down-counter reloaded on every entry to REQ
            if (state_next == LDR_REQ && state != LDR_REQ) tmr <= TW'(TIMEOUT);
            else if (state == LDR_REQ)                     tmr <= tmr - TW'(1);
        end
    end

    snn_byte_unpacker #(
        .SPLIT   (SPLIT),
        .SRAM_AW (SRAM_AW)
    ) u_unpacker (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .load     (load_word),
        .step     (sram_we),
        .word_in  (wb.dat),
        .lane     (u_lane),
        .byte_idx (u_idx),
        .bank     (u_bank),
        .addr     (u_addr),
        .data     (u_data)
    );

    assign wb.cyc = (state == LDR_REQ);
    assign wb.stb = (state == LDR_REQ);
    assign wb.we  = 1'b0;
    assign wb.sel = (state == LDR_REQ) ? 4'hF : 4'h0;
    assign wb.adr = adr;

    assign sram_we   = (state == LDR_UNPACK);
    assign sram_bank = sram_we & u_bank;
    assign sram_addr = sram_we ? u_addr : '0;
    assign sram_data = sram_we ? u_data : 8'h0;

    assign busy = (state == LDR_REQ) || (state == LDR_UNPACK);
    assign done = (state == LDR_DONE);

endmodule

// File: tb/tb_snn_wb_loader.sv
// Bench for snn_wb_loader: a behavioural Wishbone memory plus a byte-stream
// reference model that predicts every SRAM write and bus request.
module tb_snn_wb_loader;
    import snn_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src_addr = 32'h0;
    logic [11:0] byte_count = 12'd0;
    logic        sram_bank, sram_we, busy, done, error;
    logic [9:0]  sram_addr;
    logic [7:0]  sram_data;

    snn_wb_loader_if wb ();

    snn_wb_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .byte_count (byte_count),
        .wb         (wb.master),
        .sram_bank  (sram_bank),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_data  (sram_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mem_mode = 0;
    logic [31:0] base_m = 32'h0;
    logic [31:0] seed = 32'h0;
    int          lat = 0;
    bit          no_ack = 1'b0;
    int          err_req = 0;
    int          req_cnt = 0;
    int          stb_cycles = 0;
    int          done_cnt = 0;
    int          wcnt = 0;
    bit          pending = 1'b0;
    logic [31:0] req_q[$];
    logic [18:0] got_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        case (mem_mode)
            0: return (a == base_m) ? 32'h4433_2211 :
                      (a == base_m + 32'd4) ? 32'h8877_6655 : 32'hDEAD_BEEF;
            1: begin
                w = (a - base_m) >> 2;
                return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            end
            default: return (a * 32'h9E37_79B1) ^ seed;
        endcase
    endfunction

    // Byte n of the stream, packed as {bank, addr, data}
    function automatic logic [18:0] exp_entry(input int n);
        logic [31:0] w;
        logic [7:0]  b;
        bit          bk;
        w  = mem_word(base_m + 32'(4 * (n / 4)));
        b  = 8'(w >> (8 * (n % 4)));
        bk = (n >= HALF_WEIGHTS);
        return {bk, 10'(bk ? n - HALF_WEIGHTS : n), b};
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({wb.cyc, wb.stb, wb.we, wb.sel, wb.adr, sram_bank, sram_we,
                    sram_addr, sram_data, busy, done, error});
    endfunction

    // Wishbone memory: acks after `lat` wait states, or errs on request err_req
    always @(posedge clk) begin
        #2;
        wb.ack = 1'b0;
        wb.err = 1'b0;
        wb.dat = 32'h0;
        if (rst) begin
            pending = 1'b0;
        end else if (wb.cyc && wb.stb) begin
            if (!pending) begin
                pending = 1'b1;
                req_cnt++;
                req_q.push_back(wb.adr);
                wcnt = 0;
            end else begin
                chk("adr_stable", wb.adr, req_q[$]);
            end
            chk("sel_we", {wb.sel, wb.we}, {4'hF, 1'b0});
            if (!no_ack) begin
                if (wcnt >= lat) begin
                    pending = 1'b0;
                    if (req_cnt == err_req) wb.err = 1'b1;
                    else begin
                        wb.ack = 1'b1;
                        wb.dat = mem_word(wb.adr);
                    end
                end else begin
                    wcnt++;
                end
            end
        end else if (pending) begin
            if (!no_ack) chk("stb_held", wb.stb, 1'b1);
            pending = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (sram_we) got_q.push_back({sram_bank, sram_addr, sram_data});
        if (done) done_cnt++;
        if (wb.stb) stb_cycles++;
    end

    task automatic prep(input int mode, input logic [31:0] src, input int l, input bit na, input int er);
        mem_mode   = mode;
        base_m     = {src[31:2], 2'b00};
        lat        = l;
        no_ack     = na;
        err_req    = er;
        req_cnt    = 0;
        stb_cycles = 0;
        done_cnt   = 0;
        req_q.delete();
        got_q.delete();
    endtask

    task automatic pulse(input logic [31:0] src, input logic [11:0] bc);
        @(posedge clk);
        #1;
        start      = 1'b1;
        src_addr   = src;
        byte_count = bc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        bit fin = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0 || error) begin
                fin = 1'b1;
                break;
            end
        end
        chk("finished_in_budget", fin, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_results(input int n_exp, input bit exp_err, input int n_req);
        int mism = 0;
        int rmism = 0;
        chk("write_count", got_q.size(), n_exp);
        for (int n = 0; n < got_q.size() && n < n_exp; n++) begin
            if (got_q[n] !== exp_entry(n)) begin
                if (mism == 0)
                    $display("first bad write %0d: got %0h want %0h", n, got_q[n], exp_entry(n));
                mism++;
            end
        end
        chk("write_mismatches", mism, 0);
        chk("req_count", req_q.size(), n_req);
        for (int i = 0; i < req_q.size(); i++)
            if (req_q[i] !== base_m + 32'(4 * i)) rmism++;
        chk("req_addr_mismatches", rmism, 0);
        chk("done_pulses", done_cnt, exp_err ? 0 : 1);
        chk("error_flag", error, exp_err);
    endtask

    initial begin
        logic [10:0] stb_tr, we_tr, done_tr, busy_tr;
        logic [31:0] src;
        logic [11:0] bc;
        int          n;
        bit          seen;

        wb.ack = 1'b0;
        wb.err = 1'b0;
        wb.dat = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // zero-wait, two words, exact cycle trace
        prep(0, 32'h3000_0000, 0, 1'b0, 0);
        pulse(32'h3000_0000, 12'd8);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            stb_tr[i]  = wb.stb;
            we_tr[i]   = sram_we;
            done_tr[i] = done;
            busy_tr[i] = busy;
        end
        chk("t1_stb_trace", stb_tr, 11'b000_0010_0001);
        chk("t1_we_trace", we_tr, 11'b011_1101_1110);
        chk("t1_done_trace", done_tr, 11'b100_0000_0000);
        chk("t1_busy_trace", busy_tr, 11'b011_1111_1111);
        repeat (2) @(negedge clk);
        check_results(8, 1'b0, 2);

        // partial last word with wait states
        prep(0, 32'h3000_0000, 3, 1'b0, 0);
        pulse(32'h3000_0000, 12'd5);
        wait_end(200);
        check_results(5, 1'b0, 2);
        chk("t2_stb_cycles", stb_cycles, 8);

        // zero count
        prep(0, 32'h3000_0000, 0, 1'b0, 0);
        pulse(32'h3000_0000, 12'd0);
        @(negedge clk);
        chk("t3_done_next", done, 1'b1);
        chk("t3_no_cyc", wb.cyc, 1'b0);
        @(negedge clk);
        chk("t3_done_once", done, 1'b0);
        repeat (2) @(negedge clk);
        chk("t3_req_count", req_q.size(), 0);

        // bank split
        prep(1, WEIGHTS_BASE, 0, 1'b0, 0);
        pulse(WEIGHTS_BASE, 12'd984);
        wait_end(3000);
        check_results(984, 1'b0, 246);
        chk("t4_bank1_first", got_q[980], {1'b1, 10'd0, 8'hD4});

        // bus error on second request, then a fresh start clears error
        prep(0, 32'h3000_0000, 0, 1'b0, 2);
        pulse(32'h3000_0000, 12'd8);
        wait_end(200);
        check_results(4, 1'b1, 2);
        prep(0, 32'h3000_0000, 0, 1'b0, 0);
        pulse(32'h3000_0000, 12'd0);
        @(negedge clk);
        chk("t5_error_cleared", error, 1'b0);
        chk("t5_done_after_clear", done, 1'b1);
        repeat (2) @(negedge clk);

        // slave never answers
        prep(0, 32'h3000_0040, 0, 1'b1, 0);
        pulse(32'h3000_0040, 12'd4);
        wait_end(1000);
        check_results(0, 1'b1, 1);
        chk("t6_timeout_cycles", stb_cycles, 255);

        // reset in the middle of UNPACK
        prep(0, 32'h3000_0000, 0, 1'b0, 0);
        pulse(32'h3000_0000, 12'd8);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sram_we) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t7_reached_unpack", seen, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t7_reset_outputs", all_outs(), 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // start while busy is ignored
        prep(0, 32'h3000_0000, 2, 1'b0, 0);
        pulse(32'h3000_0000, 12'd8);
        repeat (2) @(posedge clk);
        pulse(32'h1234_0000, 12'd4);
        wait_end(300);
        check_results(8, 1'b0, 2);

        // randomized transfers, including address wrap and count clamp
        for (int t = 0; t < 8; t++) begin
            src  = (t == 0) ? 32'hFFFF_FFF6 : $urandom;
            bc   = (t == 0) ? 12'd24 : (t == 1) ? 12'd4000 : 12'($urandom_range(1, 40));
            seed = $urandom;
            prep(2, src, int'($urandom_range(0, 3)), 1'b0, 0);
            pulse(src, bc);
            wait_end(20000);
            n = (bc > 12'd1960) ? 1960 : int'(bc);
            check_results(n, 1'b0, (n + 3) / 4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
